cpu_ctrl_fsm_p: RTL and testbench
=================================

CPU_CTRL_FSM_P -- requirements
Module: cpu_ctrl_fsm_p

Interface
REQ-001 SHALL have parameter NREG, default 8, meaning general registers addressed by RX/RY, legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles spent waiting for mem_ready.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 run  in  1  enable continuous fetch/execute while high.
REQ-006 ir  in  16  instruction: [15:13] opcode, [12] imm flag, [11:9] RX, [2:0] RY.
REQ-007 mem_ready  in  1  memory handshake; current read/write completes this cycle.
REQ-008 z_flag  in  1  ALU zero flag for branches.
REQ-009 ir_load, a_load, g_load, addr_load, dout_load, pc_inc, pc_load  out  1 each  active-high register enables.
REQ-010 r_load  out  NREG  one-hot register write enable.
REQ-011 sel  out  4  bus mux: 0..7=R0..R7, 8=immediate, 9=G, 10=memory data.
REQ-012 op  out  2  ALU op: 00 add, 01 sub, 10 and.
REQ-013 imm_hi  out  1  immediate placed in upper byte (MVT).
REQ-014 mem_rd, mem_wr  out  1 each  memory strobes, held until mem_ready.
REQ-015 done, illegal, bus_err  out  1 each  single-cycle status pulses.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, FETCH, T1, T2, T3; outputs decode from state and ir only, with every unlisted output 0 and sel=0 (never X).
REQ-018 IDLE: when run=1, go to FETCH next edge.
REQ-019 FETCH: mem_rd=1; on mem_ready, ir_load=1 and pc_inc=1, go to T1; otherwise hold.
REQ-020 Opcodes SHALL be 000 MV, 001 MVT, 010 ADD, 011 SUB, 100 LD, 101 ST, 110 AND, 111 B.
REQ-021 T1 MV: sel=imm?8:RY, r_load[RX]=1, done. MVT: sel=8, imm_hi=1, r_load[RX]=1, done.
REQ-022 T1 ADD/SUB/AND: sel=RX, a_load=1, go to T2. LD/ST: sel=RY, addr_load=1, go to T2.
REQ-023 T1 B: conditions by RX are 000 always, 001 z_flag=1, 010 z_flag=0, others never; if taken, sel=8 and pc_load=1; always done.
REQ-024 T2 ALU ops: sel=imm?8:RY, op per opcode, g_load=1, go to T3. LD: mem_rd=1 until mem_ready, then T3. ST: sel=RX, dout_load=1, go to T3.
REQ-025 T3 ALU ops: sel=9, r_load[RX]=1, done. LD: sel=10, r_load[RX]=1, done. ST: mem_wr=1 until mem_ready, then done.
REQ-026 The done cycle is the instruction's last cycle; next state is FETCH if run=1, else IDLE.
REQ-027 Deasserting run mid-instruction SHALL NOT abort the instruction; it completes, then the FSM enters IDLE.
REQ-028 Illegal operands: in T1, if RX>=NREG, or imm=0 and RY>=NREG, for any non-B opcode, pulse illegal and done, with no load or memory strobe; then proceed per REQ-026.
REQ-029 A wait counter SHALL clear on entry to each wait state and count cycles with mem_ready=0.
REQ-030 Timeout: on reaching TIMEOUT, pulse bus_err and done, drop the strobes, and go to IDLE regardless of run.
REQ-031 mem_ready outside a wait state SHALL be ignored.

Reset
REQ-032 reset_n=0 at a rising edge SHALL force IDLE and clear the wait counter, overriding run, mem_ready and done, from any state.
REQ-033 While in reset and the cycle after, every output SHALL be 0, sel=0 and busy=0.

Verification
REQ-034 Reset in T2 of an ADD -> next cycle IDLE, all outputs 0, no r_load pulse.
REQ-035 run=1, mem_ready=1, ir=ADD R1,R2 (0x4202) -> 4 cycles; T3 has sel=9 and r_load=0x02; done=1, then FETCH.
REQ-036 LD R3,[R4] with mem_ready delayed 3 cycles -> mem_rd held 4 cycles in T2; T3 has sel=10 and r_load=0x08.
REQ-037 NREG=4, ir=MV R5,R1 -> illegal and done pulse in T1; r_load=0.
REQ-038 ST with mem_ready stuck 0, TIMEOUT=16 -> bus_err after 16 wait cycles, then IDLE with run=1.
REQ-039 B z-condition (RX=001): z_flag=1 -> pc_load=1, sel=8; z_flag=0 -> pc_load=0; both pulse done in T1.

Source files
------------

// File: rtl/cpu_ctrl_fsm_p_if.sv
// Control/handshake bundle between the instruction controller and the
// datapath/memory side. Signal suffixes are from the controller's view.
interface cpu_ctrl_fsm_p_if #(
    parameter int NREG = 8
);
    logic            run_i;
    logic [15:0]     ir_i;
    logic            mem_ready_i;
    logic            z_flag_i;

    logic            ir_load_o;
    logic            a_load_o;
    logic            g_load_o;
    logic            addr_load_o;
    logic            dout_load_o;
    logic            pc_inc_o;
    logic            pc_load_o;
    logic [NREG-1:0] r_load_o;
    logic [3:0]      sel_o;
    logic [1:0]      op_o;
    logic            imm_hi_o;
    logic            mem_rd_o;
    logic            mem_wr_o;
    logic            done_o;
    logic            illegal_o;
    logic            bus_err_o;
    logic            busy_o;

    // Controller side: consumes instruction/handshake, drives enables.
    modport master (
        input  run_i, ir_i, mem_ready_i, z_flag_i,
        output ir_load_o, a_load_o, g_load_o, addr_load_o, dout_load_o,
               pc_inc_o, pc_load_o, r_load_o, sel_o, op_o, imm_hi_o,
               mem_rd_o, mem_wr_o, done_o, illegal_o, bus_err_o, busy_o
    );

    // Datapath/memory side: supplies instruction/handshake, obeys enables.
    modport slave (
        output run_i, ir_i, mem_ready_i, z_flag_i,
        input  ir_load_o, a_load_o, g_load_o, addr_load_o, dout_load_o,
               pc_inc_o, pc_load_o, r_load_o, sel_o, op_o, imm_hi_o,
               mem_rd_o, mem_wr_o, done_o, illegal_o, bus_err_o, busy_o
    );
endinterface

// File: rtl/cpu_ctrl_fsm_p.sv
// Multi-cycle fetch/execute controller for a small 8-opcode processor.
// IDLE -> FETCH -> T1 [-> T2 -> T3]; outputs are decoded from the current
// state and the instruction word. Memory waits (FETCH, LD in T2, ST in T3)
// are bounded by a wait counter that raises bus_err after TIMEOUT stalls.
module cpu_ctrl_fsm_p #(
    parameter int NREG    = 8,
    parameter int TIMEOUT = 16
) (
    input logic              clk,
    input logic              reset_n,
    cpu_ctrl_fsm_p_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_T1,
        S_T2,
        S_T3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVT = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_LD  = 3'd4;
    localparam logic [2:0] OP_ST  = 3'd5;
    localparam logic [2:0] OP_AND = 3'd6;
    localparam logic [2:0] OP_B   = 3'd7;

    localparam logic [3:0] SEL_IMM = 4'd8;
    localparam logic [3:0] SEL_G   = 4'd9;
    localparam logic [3:0] SEL_MEM = 4'd10;

    localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_L  = CW'(TIMEOUT);
    localparam logic [3:0]    NREG_L = 4'(NREG);

    // All registered-enable and strobe outputs, cleared as one unit.
    typedef struct packed {
        logic            ir_load;
        logic            a_load;
        logic            g_load;
        logic            addr_load;
        logic            dout_load;
        logic            pc_inc;
        logic            pc_load;
        logic [NREG-1:0] r_load;
        logic [3:0]      sel;
        logic [1:0]      op;
        logic            imm_hi;
        logic            mem_rd;
        logic            mem_wr;
        logic            done;
        logic            illegal;
        logic            bus_err;
    } ctl_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    ctl_t          ctl;
    logic          last_step;

    // Instruction fields
    logic [2:0]      opc;
    logic            imm;
    logic [2:0]      rx;
    logic [2:0]      ry;
    logic            rx_ok;
    logic            ry_ok;
    logic            operands_ok;
    logic            is_alu;
    logic            b_taken;
    logic [1:0]      alu_op;
    logic [3:0]      sel_rx;
    logic [3:0]      sel_ry;
    logic [3:0]      sel_src;
    logic [NREG-1:0] rx_onehot;
    logic            in_wait;
    logic            timeout;
    logic [CW-1:0]   wcnt_inc;
    logic            unused_ir_bits;

    assign opc = bus.ir_i[15:13];
    assign imm = bus.ir_i[12];
    assign rx  = bus.ir_i[11:9];
    assign ry  = bus.ir_i[2:0];

    // Middle bits of the word carry immediate data for the datapath only.
    assign unused_ir_bits = ^bus.ir_i[8:3];

    assign rx_ok       = ({1'b0, rx} < NREG_L);
    assign ry_ok       = imm || ({1'b0, ry} < NREG_L);
    assign operands_ok = rx_ok && ry_ok;

    assign is_alu  = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND);
    assign alu_op  = (opc == OP_SUB) ? 2'b01 :
                     (opc == OP_AND) ? 2'b10 : 2'b00;

    // Branch condition selected by the RX field; codes 3..7 never branch.
    assign b_taken = (rx == 3'd0) ||
                     ((rx == 3'd1) &&  bus.z_flag_i) ||
                     ((rx == 3'd2) && !bus.z_flag_i);

    assign sel_rx    = {1'b0, rx};
    assign sel_ry    = {1'b0, ry};
    assign sel_src   = imm ? SEL_IMM : sel_ry;
    assign rx_onehot = rx_ok ? (NREG'(1) << rx) : '0;

    // Wait states are the only places mem_ready is looked at.
    assign in_wait  = (state_q == S_FETCH) ||
                      ((state_q == S_T2) && (opc == OP_LD)) ||
                      ((state_q == S_T3) && (opc == OP_ST));
    assign timeout  = in_wait && (wcnt_q >= TMO_L);
    assign wcnt_inc = wcnt_q + CW'(1);

    // Next-state and output decode; the wait counter is zero unless the
    // FSM is stalling in a wait state, so every wait entry starts at zero.
    always_comb begin
        ctl       = '0;
        last_step = 1'b0;
        state_d   = state_q;
        wcnt_d    = '0;

        if (timeout) begin
            ctl.bus_err = 1'b1;
            ctl.done    = 1'b1;
            state_d     = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.run_i) begin
                        state_d = S_FETCH;
                    end
                end

                S_FETCH: begin
                    ctl.mem_rd = 1'b1;
                    if (bus.mem_ready_i) begin
                        ctl.ir_load = 1'b1;
                        ctl.pc_inc  = 1'b1;
                        state_d     = S_T1;
                    end else begin
                        wcnt_d = wcnt_inc;
                    end
                end

                S_T1: begin
                    if ((opc != OP_B) && !operands_ok) begin
                        ctl.illegal = 1'b1;
                        last_step   = 1'b1;
                    end else begin
                        case (opc)
                            OP_MV: begin
                                ctl.sel    = sel_src;
                                ctl.r_load = rx_onehot;
                                last_step  = 1'b1;
                            end
                            OP_MVT: begin
                                ctl.sel    = SEL_IMM;
                                ctl.imm_hi = 1'b1;
                                ctl.r_load = rx_onehot;
                                last_step  = 1'b1;
                            end
                            OP_ADD, OP_SUB, OP_AND: begin
                                ctl.sel    = sel_rx;
                                ctl.a_load = 1'b1;
                                state_d    = S_T2;
                            end
                            OP_LD, OP_ST: begin
                                ctl.sel       = sel_ry;
                                ctl.addr_load = 1'b1;
                                state_d       = S_T2;
                            end
                            default: begin
                                if (b_taken) begin
                                    ctl.sel     = SEL_IMM;
                                    ctl.pc_load = 1'b1;
                                end
                                last_step = 1'b1;
                            end
                        endcase
                    end
                end

                S_T2: begin
                    if (is_alu) begin
                        ctl.sel    = sel_src;
                        ctl.op     = alu_op;
                        ctl.g_load = 1'b1;
                        state_d    = S_T3;
                    end else if (opc == OP_LD) begin
                        ctl.mem_rd = 1'b1;
                        if (bus.mem_ready_i) begin
                            state_d = S_T3;
                        end else begin
                            wcnt_d = wcnt_inc;
                        end
                    end else if (opc == OP_ST) begin
                        ctl.sel       = sel_rx;
                        ctl.dout_load = 1'b1;
                        state_d       = S_T3;
                    end else begin
                        state_d = S_IDLE;
                    end
                end

                S_T3: begin
                    if (is_alu) begin
                        ctl.sel    = SEL_G;
                        ctl.r_load = rx_onehot;
                        last_step  = 1'b1;
                    end else if (opc == OP_LD) begin
                        ctl.sel    = SEL_MEM;
                        ctl.r_load = rx_onehot;
                        last_step  = 1'b1;
                    end else if (opc == OP_ST) begin
                        ctl.mem_wr = 1'b1;
                        if (bus.mem_ready_i) begin
                            last_step = 1'b1;
                        end else begin
                            wcnt_d = wcnt_inc;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Completion: continue fetching while run is high, otherwise park.
        if (last_step) begin
            ctl.done = 1'b1;
            state_d  = bus.run_i ? S_FETCH : S_IDLE;
        end

        // Outputs stay quiet while reset is held, whatever the state.
        if (!reset_n) begin
            ctl = '0;
        end
    end

    // State and wait-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus.ir_load_o   = ctl.ir_load;
    assign bus.a_load_o    = ctl.a_load;
    assign bus.g_load_o    = ctl.g_load;
    assign bus.addr_load_o = ctl.addr_load;
    assign bus.dout_load_o = ctl.dout_load;
    assign bus.pc_inc_o    = ctl.pc_inc;
    assign bus.pc_load_o   = ctl.pc_load;
    assign bus.r_load_o    = ctl.r_load;
    assign bus.sel_o       = ctl.sel;
    assign bus.op_o        = ctl.op;
    assign bus.imm_hi_o    = ctl.imm_hi;
    assign bus.mem_rd_o    = ctl.mem_rd;
    assign bus.mem_wr_o    = ctl.mem_wr;
    assign bus.done_o      = ctl.done;
    assign bus.illegal_o   = ctl.illegal;
    assign bus.bus_err_o   = ctl.bus_err;
    assign bus.busy_o      = reset_n && (state_q != S_IDLE);

endmodule

// File: tb/tb_cpu_ctrl_fsm_p.sv
// Bench for cpu_ctrl_fsm_p: two instances (NREG=8/TIMEOUT=16 and
// NREG=4/TIMEOUT=5) share one stimulus stream; an instruction-level model
// predicts every output on every cycle, and directed scenarios pin the
// model with literal expectations.
module tb_cpu_ctrl_fsm_p;

    typedef struct packed {
        logic       ir_load;
        logic       a_load;
        logic       g_load;
        logic       addr_load;
        logic       dout_load;
        logic       pc_inc;
        logic       pc_load;
        logic [7:0] r_load;
        logic [3:0] sel;
        logic [1:0] op;
        logic       imm_hi;
        logic       mem_rd;
        logic       mem_wr;
        logic       done;
        logic       illegal;
        logic       bus_err;
        logic       busy;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic        z_flag = 1'b0;
    logic [15:0] ir = 16'h0000;

    int vectors = 0;
    int errors  = 0;

    int m_ph[2];
    int m_wc[2];
    int n_ph[2];
    int n_wc[2];

    always #5 clk = ~clk;

    cpu_ctrl_fsm_p_if #(.NREG(8)) if8 ();
    cpu_ctrl_fsm_p_if #(.NREG(4)) if4 ();

    assign if8.run_i       = run;
    assign if8.ir_i        = ir;
    assign if8.mem_ready_i = mem_ready;
    assign if8.z_flag_i    = z_flag;
    assign if4.run_i       = run;
    assign if4.ir_i        = ir;
    assign if4.mem_ready_i = mem_ready;
    assign if4.z_flag_i    = z_flag;

    cpu_ctrl_fsm_p #(.NREG(8), .TIMEOUT(16)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(if8.master));
    cpu_ctrl_fsm_p #(.NREG(4), .TIMEOUT(5)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(if4.master));

    outs_t act8, act4;
    assign act8 = {if8.ir_load_o, if8.a_load_o, if8.g_load_o, if8.addr_load_o,
                   if8.dout_load_o, if8.pc_inc_o, if8.pc_load_o, if8.r_load_o,
                   if8.sel_o, if8.op_o, if8.imm_hi_o, if8.mem_rd_o, if8.mem_wr_o,
                   if8.done_o, if8.illegal_o, if8.bus_err_o, if8.busy_o};
    assign act4 = {if4.ir_load_o, if4.a_load_o, if4.g_load_o, if4.addr_load_o,
                   if4.dout_load_o, if4.pc_inc_o, if4.pc_load_o, 4'b0000, if4.r_load_o,
                   if4.sel_o, if4.op_o, if4.imm_hi_o, if4.mem_rd_o, if4.mem_wr_o,
                   if4.done_o, if4.illegal_o, if4.bus_err_o, if4.busy_o};

    // Instruction-level model. ph: 0 idle, 1 fetch, 2..4 = execute step 1..3.
    // Each instruction is described by its length, its legality and which
    // step (if any) waits on memory.
    function automatic outs_t model_eval(input int ph, input int wc, input int nreg,
                                         input int tmo, input logic rst_n,
                                         input logic run_v, input logic [15:0] irv,
                                         input logic rdy, input logic zf,
                                         output int nph, output int nwc);
        outs_t o;
        int opc, rx, ry, step;
        bit imm, legal, alu, waiting, last, taken;
        o = '0;
        nph = 0;
        nwc = 0;
        if (!rst_n) return o;
        if (ph == 0) begin
            nph = run_v ? 1 : 0;
            return o;
        end
        o.busy  = 1'b1;
        opc     = int'(irv[15:13]);
        imm     = irv[12];
        rx      = int'(irv[11:9]);
        ry      = int'(irv[2:0]);
        step    = ph - 1;
        legal   = (opc == 7) || ((rx < nreg) && (imm || (ry < nreg)));
        alu     = (opc == 2) || (opc == 3) || (opc == 6);
        waiting = (step == 0) || (opc == 4 && step == 2) || (opc == 5 && step == 3);
        last    = (step == 3) ||
                  (step == 1 && (!legal || opc == 0 || opc == 1 || opc == 7));
        if (waiting) begin
            if (wc >= tmo) begin
                o.bus_err = 1'b1;
                o.done    = 1'b1;
                return o;
            end
            if (step == 3) o.mem_wr = 1'b1;
            else           o.mem_rd = 1'b1;
            if (!rdy) begin
                nwc = wc + 1;
                nph = ph;
                return o;
            end
            if (step == 0) begin
                o.ir_load = 1'b1;
                o.pc_inc  = 1'b1;
            end
        end else if (step == 1) begin
            if (!legal) begin
                o.illegal = 1'b1;
            end else if (opc == 0) begin
                o.sel    = 4'(imm ? 8 : ry);
                o.r_load = 8'(1 << rx);
            end else if (opc == 1) begin
                o.sel    = 4'd8;
                o.imm_hi = 1'b1;
                o.r_load = 8'(1 << rx);
            end else if (alu) begin
                o.sel    = 4'(rx);
                o.a_load = 1'b1;
            end else if (opc == 4 || opc == 5) begin
                o.sel       = 4'(ry);
                o.addr_load = 1'b1;
            end else begin
                taken = (rx == 0) || (rx == 1 && zf) || (rx == 2 && !zf);
                if (taken) begin
                    o.sel     = 4'd8;
                    o.pc_load = 1'b1;
                end
            end
        end else if (step == 2) begin
            if (alu) begin
                o.sel    = 4'(imm ? 8 : ry);
                o.op     = 2'((opc == 2) ? 0 : ((opc == 3) ? 1 : 2));
                o.g_load = 1'b1;
            end else if (opc == 5) begin
                o.sel       = 4'(rx);
                o.dout_load = 1'b1;
            end
        end else begin
            if (alu) begin
                o.sel    = 4'd9;
                o.r_load = 8'(1 << rx);
            end else if (opc == 4) begin
                o.sel    = 4'd10;
                o.r_load = 8'(1 << rx);
            end
        end
        if (last) begin
            o.done = 1'b1;
            nph    = run_v ? 1 : 0;
        end else begin
            nph = ph + 1;
        end
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    initial begin
        outs_t exp_o, act_o;
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0;
            m_wc[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                exp_o = model_eval(m_ph[i], m_wc[i], (i == 0) ? 8 : 4, (i == 0) ? 16 : 5,
                                   reset_n, run, ir, mem_ready, z_flag, n_ph[i], n_wc[i]);
                act_o = (i == 0) ? act8 : act4;
                vectors++;
                if (act_o !== exp_o) begin
                    errors++;
                    $display("FAIL cycle_check inst%0d t=%0t ir=%h: dut=%h model=%h",
                             i, $time, ir, act_o, exp_o);
                end
            end
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                m_ph[i] = n_ph[i];
                m_wc[i] = n_wc[i];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(if8.busy_o), 0);
        repeat (2) cyc();
        reset_n = 1'b1;
    endtask

    // Stimulus: directed scenarios with literal checks, then random traffic.
    initial begin
        int cnt8, cnt4, bias;
        bit seen8, seen4, wr_at_err, done_at_err;
        int sel_r[5], rl_r[5], done_r[5], rd_r[5], al_r[5];
        int bias_tab[5] = '{0, 2, 5, 7, 8};

        // ADD R1,R2 with memory always ready
        do_reset();
        run = 1'b1; ir = 16'h4202; mem_ready = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sel_r[i] = int'(if8.sel_o); rl_r[i] = int'(if8.r_load_o);
            done_r[i] = int'(if8.done_o); rd_r[i] = int'(if8.mem_rd_o);
            al_r[i] = int'(if8.a_load_o);
            cyc();
        end
        chk("add_fetch_rd", rd_r[0], 1);
        chk("add_t1_aload", al_r[1], 1);
        chk("add_t3_sel", sel_r[3], 9);
        chk("add_t3_rload", rl_r[3], 2);
        chk("add_done_once", done_r[0] + done_r[1] + done_r[2] + done_r[3], 1);
        chk("add_done_t3", done_r[3], 1);
        chk("add_then_fetch", rd_r[4], 1);

        // Reset during T2 of ADD
        do_reset();
        run = 1'b1; ir = 16'h4202; mem_ready = 1'b1;
        cyc(); cyc(); cyc();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_t2_gload", int'(if8.g_load_o), 0);
        chk("rst_t2_busy", int'(if8.busy_o), 0);
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_after_busy", int'(if8.busy_o), 0);
        chk("rst_after_rload", int'(if8.r_load_o), 0);
        cyc();
        @(negedge clk);
        chk("rst_then_fetch", int'(if8.mem_rd_o), 1);

        // LD R3,[R4] with mem_ready delayed three cycles in T2
        do_reset();
        run = 1'b1; ir = 16'h8604; mem_ready = 1'b1;
        cyc(); cyc(); cyc();
        cnt8 = 0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            @(negedge clk);
            if (if8.mem_rd_o) cnt8++;
            cyc();
        end
        @(negedge clk);
        chk("ld_rd_cycles", cnt8, 4);
        chk("ld_t3_sel", int'(if8.sel_o), 10);
        chk("ld_t3_rload", int'(if8.r_load_o), 8);
        chk("ld_t3_done", int'(if8.done_o), 1);

        // MV R5,R1: legal with 8 registers, illegal with 4
        do_reset();
        run = 1'b1; ir = 16'h0A01; mem_ready = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("mv_n4_illegal", int'(if4.illegal_o), 1);
        chk("mv_n4_done", int'(if4.done_o), 1);
        chk("mv_n4_rload", int'(if4.r_load_o), 0);
        chk("mv_n8_rload", int'(if8.r_load_o), 32);
        chk("mv_n8_illegal", int'(if8.illegal_o), 0);

        // B on z_flag (RX=001), taken then not taken
        do_reset();
        run = 1'b1; ir = 16'hE200; mem_ready = 1'b1; z_flag = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("bz1_pcload", int'(if8.pc_load_o), 1);
        chk("bz1_sel", int'(if8.sel_o), 8);
        chk("bz1_done", int'(if8.done_o), 1);
        cyc(); cyc();
        z_flag = 1'b0;
        @(negedge clk);
        chk("bz0_pcload", int'(if8.pc_load_o), 0);
        chk("bz0_done", int'(if8.done_o), 1);

        // ST R2,[R3] with mem_ready stuck low
        do_reset();
        run = 1'b1; ir = 16'hA403; mem_ready = 1'b1;
        cyc(); cyc();
        mem_ready = 1'b0;
        cyc(); cyc();
        cnt8 = 0; cnt4 = 0; seen8 = 0; seen4 = 0; wr_at_err = 1; done_at_err = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!seen4) begin
                if (if4.bus_err_o) seen4 = 1;
                else if (if4.mem_wr_o) cnt4++;
            end
            if (if8.bus_err_o) begin
                seen8 = 1;
                wr_at_err = if8.mem_wr_o;
                done_at_err = if8.done_o;
                break;
            end
            if (if8.mem_wr_o) cnt8++;
            cyc();
        end
        chk("st_buserr_seen", int'(seen8), 1);
        chk("st_wr_cycles", cnt8, 16);
        chk("st_wr_dropped", int'(wr_at_err), 0);
        chk("st_err_done", int'(done_at_err), 1);
        chk("st_n4_wr_cycles", cnt4, 5);
        cyc();
        @(negedge clk);
        chk("st_err_idle", int'(if8.busy_o), 0);
        cyc();
        @(negedge clk);
        chk("st_err_refetch", int'(if8.mem_rd_o), 1);

        // Random traffic; ir only changes while neither instance is mid-instruction
        do_reset();
        bias = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) bias = bias_tab[$urandom_range(0, 4)];
            reset_n   = ($urandom_range(0, 299) != 0);
            run       = ($urandom_range(0, 15) != 0);
            mem_ready = (int'($urandom_range(0, 7)) >= bias);
            z_flag    = $urandom_range(0, 1) != 0;
            if (m_ph[0] <= 1 && m_ph[1] <= 1 && $urandom_range(0, 1) != 0)
                ir = 16'($urandom);
            cyc();
        end

        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
